// File: rtl/twinkle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : twinkle_sequencer
// Purpose  : Produces the 4-bit pattern index for the eight-LED breathing
//            display. Three raw push-buttons (next / prev / auto) are
//            synchronised and debounced. The index is then stepped by hand
//            or advanced automatically on a dwell timer.
// Ports    : clk      - system clock, all logic on the rising edge
//            rst      - synchronous active-high reset
//            btn_next - raw async button, step index forward
//            btn_prev - raw async button, step index backward
//            btn_auto - raw async button, toggle AUTO / MANUAL
//            hold     - synchronous level, freezes the dwell counter
//            state    - pattern index, 0 .. NSTATES-1
//            auto_on  - high while the sequencer is in AUTO
//            step     - one-cycle pulse in the cycle after state changed
// Options  : SEQ_BOUNCE_EN - when defined, AUTO advance ping-pongs between
//            0 and NSTATES-1 instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module twinkle_sequencer #(
    parameter int NSTATES    = 14,
    parameter int DWELL      = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_auto,
    input  logic       hold,
    output logic [3:0] state,
    output logic       auto_on,
    output logic       step
);

    localparam int c_DW_W = $clog2(DWELL);
    localparam int c_DB_W = $clog2(DEB_CYCLES + 1);

    localparam logic [3:0]        c_LAST       = 4'(NSTATES - 1);
    localparam logic [c_DW_W-1:0] c_DWELL_LAST = c_DW_W'(DWELL - 1);
    localparam logic [c_DB_W-1:0] c_DEB_LAST   = c_DB_W'(DEB_CYCLES - 1);

    // Button bit order used throughout: [0]=next, [1]=prev, [2]=auto
    localparam int c_NBTN = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_AUTO   = 2'd2
    } fsm_t;

    // ------------------------------------------------------------------------
    // Button conditioning: 2-flop synchroniser, then a level must persist for
    // DEB_CYCLES consecutive cycles before it is accepted. Any return to the
    // accepted level restarts the count.
    // ------------------------------------------------------------------------
    logic [c_NBTN-1:0] w_raw;
    logic [c_NBTN-1:0] w_press;

    assign w_raw = {btn_auto, btn_prev, btn_next};

    generate
        for (genvar gi = 0; gi < c_NBTN; gi++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_stable;
            logic              r_stable_d;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (r_sync2 != r_stable) begin
                        if (r_cnt == c_DEB_LAST) begin
                            r_stable <= r_sync2;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            // Rising edge of the accepted level; releases generate nothing.
            assign w_press[gi] = r_stable & ~r_stable_d;
        end
    endgenerate

    // Auto has priority; next and prev together cancel each other.
    logic w_auto_p;
    logic w_next_p;
    logic w_prev_p;

    assign w_auto_p = w_press[2];
    assign w_next_p = w_press[0] & ~w_press[1] & ~w_auto_p;
    assign w_prev_p = w_press[1] & ~w_press[0] & ~w_auto_p;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    fsm_t              r_fsm;
    fsm_t              w_fsm_nxt;
    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [c_DW_W-1:0] r_dwell;
    logic [c_DW_W-1:0] w_dwell_nxt;
    logic              r_auto_on;
    logic              r_step;

`ifdef SEQ_BOUNCE_EN
    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;
    logic            r_dir;
    logic            w_dir_nxt;
`endif

    function automatic logic [3:0] f_inc(input logic [3:0] s);
        return (s == c_LAST) ? 4'd0 : s + 4'd1;
    endfunction

    function automatic logic [3:0] f_dec(input logic [3:0] s);
        return (s == 4'd0) ? c_LAST : s - 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= S_IDLE;
            r_state   <= 4'd0;
            r_dwell   <= '0;
            r_auto_on <= 1'b0;
            r_step    <= 1'b0;
`ifdef SEQ_BOUNCE_EN
            r_dir     <= c_DIR_UP;
`endif
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_state   <= w_state_nxt;
            r_dwell   <= w_dwell_nxt;
            r_auto_on <= (w_fsm_nxt == S_AUTO);
            // Covers wraps too: any differing index flags a step.
            r_step    <= (w_state_nxt != r_state);
`ifdef SEQ_BOUNCE_EN
            r_dir     <= w_dir_nxt;
`endif
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
`ifdef SEQ_BOUNCE_EN
        w_dir_nxt   = r_dir;
`endif
        case (r_fsm)
            S_IDLE: begin
                w_state_nxt = 4'd0;
                if (w_auto_p) begin
                    w_fsm_nxt   = S_AUTO;
                    w_dwell_nxt = '0;
                end else if (w_next_p) begin
                    w_fsm_nxt   = S_MANUAL;
                    w_state_nxt = 4'd1;
                end else if (w_prev_p) begin
                    w_fsm_nxt   = S_MANUAL;
                    w_state_nxt = c_LAST;
                end
            end

            S_MANUAL: begin
                if (w_auto_p) begin
                    w_fsm_nxt   = S_AUTO;
                    w_dwell_nxt = '0;
                end else if (w_next_p) begin
                    w_state_nxt = f_inc(r_state);
                end else if (w_prev_p) begin
                    w_state_nxt = f_dec(r_state);
                end
            end

            S_AUTO: begin
                // A manual step takes precedence over a coincident expiry,
                // so only one step happens on that edge.
                if (w_auto_p) begin
                    w_fsm_nxt   = S_MANUAL;
                    w_dwell_nxt = '0;
                end else if (w_next_p) begin
                    w_state_nxt = f_inc(r_state);
                    w_dwell_nxt = '0;
                end else if (w_prev_p) begin
                    w_state_nxt = f_dec(r_state);
                    w_dwell_nxt = '0;
                end else if (!hold) begin
                    if (r_dwell == c_DWELL_LAST) begin
                        w_dwell_nxt = '0;
`ifdef SEQ_BOUNCE_EN
                        if (r_dir == c_DIR_UP) begin
                            if (r_state == c_LAST) begin
                                w_state_nxt = r_state - 4'd1;
                                w_dir_nxt   = c_DIR_DOWN;
                            end else begin
                                w_state_nxt = r_state + 4'd1;
                            end
                        end else begin
                            if (r_state == 4'd0) begin
                                w_state_nxt = 4'd1;
                                w_dir_nxt   = c_DIR_UP;
                            end else begin
                                w_state_nxt = r_state - 4'd1;
                            end
                        end
`else
                        w_state_nxt = f_inc(r_state);
`endif
                    end else begin
                        w_dwell_nxt = r_dwell + 1'b1;
                    end
                end
            end

            default: begin
                w_fsm_nxt   = S_IDLE;
                w_state_nxt = 4'd0;
                w_dwell_nxt = '0;
            end
        endcase
    end

    assign state   = r_state;
    assign auto_on = r_auto_on;
    assign step    = r_step;

endmodule
`default_nettype wire

// File: doc/twinkle_sequencer.md
Name: twinkle_sequencer

Overview:
- Generates the 4-bit `state` pattern index that drives the eight-LED breathing display (`twinkle8`).
- Debounces three raw push-buttons: next, prev and auto.
- Sequences the index manually, or automatically on a dwell timer.
- Sits between the board buttons and the LED pattern block; one instance per board.

Parameters:
- NSTATES, 14, number of pattern indices, valid 2..16; state ranges 0..NSTATES-1.
- DWELL, 50000000, clock cycles each index is held in AUTO mode (≥2).
- DEB_CYCLES, 1000000, cycles a synchronised button must hold a new level before it is accepted (≥1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_next  in  1  raw button, asynchronous, active-high.
- btn_prev  in  1  raw button, asynchronous, active-high.
- btn_auto  in  1  raw button, asynchronous, active-high; toggles AUTO/MANUAL.
- hold  in  1  synchronous level; freezes the dwell counter while high.
- state  out  4  pattern index to the LED block.
- auto_on  out  1  high while FSM is in AUTO.
- step  out  1  one-cycle pulse on the cycle after any change of `state`.

Behaviour:
- Reset, synchronous on `rst`:
  - Outputs: state=0, auto_on=0, step=0; FSM=IDLE.
  - Internals: dwell counter=0; all debounce stable levels and counters=0; dir=up.
  - `rst` mid-operation overrides everything, including a press on the same edge.
- Button conditioning, per button:
  - 2-flop synchroniser, then a debounce counter.
  - On each edge, if sync2≠stable: when cnt==DEB_CYCLES-1, stable<=sync2 and cnt<=0; otherwise cnt++.
  - If sync2==stable, cnt<=0; any glitch shorter than DEB_CYCLES restarts the count.
  - Press pulse = stable & ~stable_prev, one cycle wide.
  - Raw input first sampled high at edge k and held: stable rises at edge k+1+DEB_CYCLES, and `state` / mode update at edge k+2+DEB_CYCLES.
  - Release is debounced identically but produces no event.
- Press priority in one cycle: auto > next/prev. next and prev together are both ignored.
- FSM states and transitions:
  - IDLE: state held at 0 (all LEDs breathe).
    - next → MANUAL, state=1.
    - prev → MANUAL, state=NSTATES-1.
    - auto → AUTO, state stays 0, dwell=0.
  - MANUAL:
    - next: state=(state==NSTATES-1)?0:state+1.
    - prev: state=(state==0)?NSTATES-1:state-1.
    - auto → AUTO, dwell=0, state unchanged.
  - AUTO:
    - Dwell counter increments each cycle unless `hold`=1.
    - At dwell==DWELL-1 with hold=0: index advances and dwell<=0, so each index is held exactly DWELL cycles when hold=0.
    - next/prev step exactly as in MANUAL and clear dwell.
    - A manual step wins over a coincident dwell expiry (a single step only).
    - auto → MANUAL, state held, dwell=0.
- Outputs:
  - auto_on is registered, equal to (FSM==AUTO).
  - step is registered: high for the single cycle after any edge where `state` changed.
  - A wrap from NSTATES-1 to 0 counts as a change.
- Widths:
  - Dwell counter width = $clog2(DWELL).
  - Debounce counter width = $clog2(DEB_CYCLES+1).
  - `state` is compared only against NSTATES-1 and never exceeds it.

Optional Feature:
- Macro: SEQ_BOUNCE_EN.
- Defined: AUTO advance ping-pongs.
  - Register `dir` (reset up) sets the direction.
  - At state NSTATES-1 with dir=up, the next auto step goes to NSTATES-2 and sets dir=down.
  - At state 0 with dir=down, the next auto step goes to 1 and sets dir=up.
  - Manual next/prev ignore and do not modify `dir`.
- Undefined: AUTO always increments with wrap NSTATES-1→0; no `dir` register exists.

Test Plan:
(All with NSTATES=14, DWELL=4, DEB_CYCLES=3 unless noted.)
- Reset, then btn_next held high from edge 10 → state=1 at edge 15; step=1 in the following cycle only; auto_on=0.
- btn_next glitch: high 2 cycles, low, repeated 5 times → state stays 0; step never asserted.
- IDLE, press prev → state=13. Press next → 0. Press next → 1. Confirms wrap both ways.
- Press auto → auto_on=1; state advances 0→1→2 every 4 cycles. Hold=1 for 10 cycles → state frozen, then resumes with the remaining dwell. Press next mid-dwell → immediate step, next auto step 4 cycles later.
- In AUTO, auto and next pressed on the same edge → auto_on=0, state unchanged. next and prev together in MANUAL → no change. rst asserted mid-dwell → state=0, auto_on=0 on the next edge.
- SEQ_BOUNCE_EN defined, AUTO from state 12 → sequence 12,13,12,11,…,1,0,1; without the macro → 12,13,0,1.
